otter_timer_counter: RTL and testbench

Memory-mapped programmable down-counter on the OTTER I/O bus. It sits directly downstream of the processor's IOBUS write port, decoding `IOBUS_ADDR`/`IOBUS_OUT`/`IOBUS_WR`. It returns read data for the top-level `IOBUS_IN` mux and drives the processor `INTR` input. It provides periodic or one-shot interrupts with an 8-bit prescaler and a 32-bit reload value.

---
 rtl/otter_timer_counter.sv | 149 ++++++++++++++
 tb/tb_otter_timer_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/otter_timer_counter.sv
// otter_timer_counter: memory-mapped programmable down-counter for the OTTER I/O bus.
//
// Register window of four words at BASE_ADDR:
//   0x0 CTRL   : bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE
//   0x4 LOAD   : reload value; a write also loads COUNT and clears the prescaler
//   0x8 COUNT  : current count; a write loads it directly and clears the prescaler
//   0xC STATUS : bit0 PENDING, write-1-to-clear
//
// Ports:
//   clk        : system clock
//   RST        : synchronous active-high reset
//   IOBUS_ADDR : byte address from the processor
//   IOBUS_OUT  : write data from the processor
//   IOBUS_WR   : single-cycle write strobe
//   RD_DATA    : combinational read data, 0 outside the window
//   INTR       : level interrupt, PENDING & IRQ_EN
module otter_timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_00D0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        INTR
);

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;

  logic       hit;
  logic [1:0] offset;
  logic       wr_ctrl, wr_load, wr_count, wr_status;
  logic       tick;
  logic       expiry;

  // Address byte lanes and unimplemented CTRL bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16], IOBUS_OUT[7:3]};

  assign hit    = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign offset = IOBUS_ADDR[3:2];

  assign wr_ctrl   = IOBUS_WR && hit && (offset == 2'd0);
  assign wr_load   = IOBUS_WR && hit && (offset == 2'd1);
  assign wr_count  = IOBUS_WR && hit && (offset == 2'd2);
  assign wr_status = IOBUS_WR && hit && (offset == 2'd3);

  assign tick = en_q && (pre_cnt_q == prescale_q);
  // A COUNT/LOAD write in the same cycle overrides the tick entirely.
  assign expiry = tick && (count_q == 32'd0) && !wr_load && !wr_count;

  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    count_d    = count_q;
    pending_d  = pending_q;
    pre_cnt_d  = pre_cnt_q;

    // Prescaler
    if (en_q) begin
      pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;
    end

    // Counter
    if (wr_load) begin
      load_d    = IOBUS_OUT;
      count_d   = IOBUS_OUT;
      pre_cnt_d = 8'd0;
    end else if (wr_count) begin
      count_d   = IOBUS_OUT;
      pre_cnt_d = 8'd0;
    end else if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (auto_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // CTRL write lands after the one-shot clear so the written EN wins.
    if (wr_ctrl) begin
      en_d       = IOBUS_OUT[0];
      auto_d     = IOBUS_OUT[1];
      irq_en_d   = IOBUS_OUT[2];
      prescale_d = IOBUS_OUT[15:8];
      if (IOBUS_OUT[0] && !en_q) begin
        pre_cnt_d = 8'd0;
      end
    end

    // Set beats clear when W1C and expiry coincide.
    if (wr_status && IOBUS_OUT[0]) begin
      pending_d = 1'b0;
    end
    if (expiry) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= 8'd0;
      load_q     <= 32'd0;
      count_q    <= 32'd0;
      pending_q  <= 1'b0;
      pre_cnt_q  <= 8'd0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end

  always_comb begin
    RD_DATA = 32'd0;
    if (hit) begin
      unique case (offset)
        2'd0:    RD_DATA = {16'd0, prescale_q, 5'd0, irq_en_q, auto_q, en_q};
        2'd1:    RD_DATA = load_q;
        2'd2:    RD_DATA = count_q;
        default: RD_DATA = {31'd0, pending_q};
      endcase
    end
  end

  assign INTR = pending_q && irq_en_q;

endmodule

// File: tb/tb_otter_timer_counter.sv
module tb_otter_timer_counter;

  localparam logic [31:0] Base    = 32'h1100_00D0;
  localparam logic [31:0] ACtrl   = Base + 32'h0;
  localparam logic [31:0] ALoad   = Base + 32'h4;
  localparam logic [31:0] ACount  = Base + 32'h8;
  localparam logic [31:0] AStatus = Base + 32'hC;

  logic        clk;
  logic        RST;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        INTR;

  int total;
  int bad;

  otter_timer_counter #(.BASE_ADDR(Base)) dut (
    .clk        (clk),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .INTR       (INTR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    step();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    IOBUS_ADDR = addr;
    #1;
    check(tag, RD_DATA, exp);
  endtask

  initial begin
    logic saw_intr;
    total      = 0;
    bad        = 0;
    RST        = 1'b1;
    IOBUS_ADDR = 32'd0;
    IOBUS_OUT  = 32'd0;
    IOBUS_WR   = 1'b0;

    // 1. Reset
    step();
    step();
    RST = 1'b0;
    read_check("rst_ctrl",   ACtrl,   32'd0);
    read_check("rst_load",   ALoad,   32'd0);
    read_check("rst_count",  ACount,  32'd0);
    read_check("rst_status", AStatus, 32'd0);
    check("rst_intr", {31'd0, INTR}, 32'd0);
    read_check("rst_outside", 32'h1100_00E0, 32'd0);

    // 2. Periodic, LOAD=3, PRESCALE=0
    bus_write(ALoad, 32'd3);                               // e0
    read_check("load_rd", ALoad, 32'd3);
    read_check("load_bytelane", Base + 32'h5, 32'd3);
    read_check("outside_window", 32'h1100_00E4, 32'd0);
    bus_write(32'h1100_00E4, 32'h55);                      // miss: ignored, no enable yet
    read_check("miss_wr_ignored", ALoad, 32'd3);
    bus_write(ACtrl, 32'h7);                               // e1
    read_check("ctrl_rd", ACtrl, 32'h7);
    step(); read_check("per_cnt_e2", ACount, 32'd2);
    step(); read_check("per_cnt_e3", ACount, 32'd1);
    step(); read_check("per_cnt_e4", ACount, 32'd0);
    read_check("per_pend_e4", AStatus, 32'd0);
    step();                                                // e5 expiry
    read_check("per_pend_e5", AStatus, 32'd1);
    check("per_intr_e5", {31'd0, INTR}, 32'd1);
    read_check("per_reload_e5", ACount, 32'd3);
    bus_write(AStatus, 32'd1);                             // e6
    read_check("per_w1c", AStatus, 32'd0);
    check("per_intr_w1c", {31'd0, INTR}, 32'd0);
    step(); step();                                        // e8
    read_check("per_pend_e8", AStatus, 32'd0);
    step();                                                // e9
    read_check("per_pend_e9", AStatus, 32'd1);
    bus_write(AStatus, 32'd1);                             // e10
    step(); step();                                        // e12
    read_check("per_pend_e12", AStatus, 32'd0);
    step();                                                // e13
    read_check("per_pend_e13", AStatus, 32'd1);
    bus_write(ACtrl, 32'h0);
    bus_write(AStatus, 32'd1);
    read_check("stop_pend", AStatus, 32'd0);

    // 3. Prescaled one-shot: LOAD=1, PRESCALE=2
    bus_write(ALoad, 32'd1);
    bus_write(ACtrl, 32'h0000_0205);                       // edge E
    for (int i = 0; i < 5; i++) step();                    // E+5
    read_check("os_pend_e5", AStatus, 32'd0);
    read_check("os_cnt_e5", ACount, 32'd0);
    step();                                                // E+6 expiry
    read_check("os_pend_e6", AStatus, 32'd1);
    check("os_intr", {31'd0, INTR}, 32'd1);
    read_check("os_cnt", ACount, 32'd0);
    read_check("os_ctrl_en_clr", ACtrl, 32'h0000_0204);
    bus_write(AStatus, 32'd1);
    for (int i = 0; i < 10; i++) step();
    read_check("os_no_repeat", AStatus, 32'd0);
    read_check("os_cnt_hold", ACount, 32'd0);

    // 4a. W1C in the expiry cycle; 5. IRQ gating
    bus_write(ALoad, 32'd2);
    bus_write(ACtrl, 32'h3);                               // E: count 2, auto, no IRQ
    step();                                                // E+1: count 1
    read_check("col_cnt_pre", ACount, 32'd1);
    step();                                                // E+2: count 0
    bus_write(AStatus, 32'd1);                             // E+3: expiry edge
    read_check("col_w1c_set_wins", AStatus, 32'd1);
    read_check("col_reload", ACount, 32'd2);
    check("gate_intr_off", {31'd0, INTR}, 32'd0);
    bus_write(ACtrl, 32'h7);                               // E+4: count 1
    check("gate_intr_on", {31'd0, INTR}, 32'd1);

    // 4b. COUNT write in the expiry tick cycle
    bus_write(AStatus, 32'd1);                             // E+5: count 0
    read_check("col_cnt_zero", ACount, 32'd0);
    bus_write(ACount, 32'd10);                             // E+6: would have expired
    read_check("col_cnt_wr_wins", ACount, 32'd10);
    read_check("col_no_expiry", AStatus, 32'd0);
    step();
    read_check("col_cnt_dec", ACount, 32'd9);

    // 6. Reset mid-operation
    bus_write(ACount, 32'd2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    read_check("mid_ctrl",   ACtrl,   32'd0);
    read_check("mid_load",   ALoad,   32'd0);
    read_check("mid_count",  ACount,  32'd0);
    read_check("mid_status", AStatus, 32'd0);
    saw_intr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (INTR) saw_intr = 1'b1;
    end
    check("mid_no_intr", {31'd0, saw_intr}, 32'd0);
    read_check("mid_status_end", AStatus, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
